program_counter: RTL and testbench

- Registered program counter for the Hack-style CPU datapath; holds the address of the next instruction.
- Each rising clock edge applies exactly one action, in priority order: reset, then load, then increment, otherwise hold.
- The output feeds instruction-memory addressing.
- Jump targets arrive on `in` from the ALU/A-register path.

---
 rtl/program_counter.sv | 58 +++++
 tb/tb_program_counter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/program_counter.sv
// Registered Hack-style program counter: reset > load > increment > hold, one action per edge.
// Optional macro PC_WRAP_FLAG_EN adds a registered `wrap` pulse when increment rolls over all-ones.
module program_counter #(
    parameter int unsigned      WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
`ifdef PC_WRAP_FLAG_EN
    output logic             wrap,
`endif
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] r_count = RESET_VALUE;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_next = r_count;
        if (load) begin
            w_next = in;
        end else if (inc) begin
            w_next = r_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= RESET_VALUE;
        end else begin
            r_count <= w_next;
        end
    end

    assign out = r_count;

`ifdef PC_WRAP_FLAG_EN
    logic r_wrap = 1'b0;
    logic w_wrap_next;

    // Only the increment path can roll over; a load of zero is not a wrap.
    assign w_wrap_next = !load && inc && (&r_count);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_next;
        end
    end

    assign wrap = r_wrap;
`endif

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed plan plus randomized traffic vs. an arithmetic model.
module tb_program_counter;

    localparam int unsigned W   = 16;
    localparam int unsigned MOD = 1 << W;
    localparam int unsigned RV  = 0;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] in = '0;
    logic         load = 1'b0;
    logic         inc = 1'b0;
    logic [W-1:0] out;
`ifdef PC_WRAP_FLAG_EN
    logic         wrap;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference state
    int unsigned m_count = RV;
    int unsigned m_wrap  = 0;

    program_counter #(
        .WIDTH      (W),
        .RESET_VALUE(16'h0000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .in   (in),
        .load (load),
        .inc  (inc),
`ifdef PC_WRAP_FLAG_EN
        .wrap (wrap),
`endif
        .out  (out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq(tag, {16'h0, out}, m_count);
`ifdef PC_WRAP_FLAG_EN
        check_eq({tag, "_wrap"}, {31'h0, wrap}, m_wrap);
`endif
    endtask

    // Apply one set of inputs across one rising edge, update the model, then check.
    task automatic step(input logic r, input logic l, input logic i, input logic [W-1:0] d,
                        input string tag);
        int unsigned prev;
        reset = r;
        load  = l;
        inc   = i;
        in    = d;
        @(posedge clk);
        prev   = m_count;
        m_wrap = 0;
        if (r) begin
            m_count = RV;
        end else if (l) begin
            m_count = d;
        end else if (i) begin
            m_count = (prev + 1) % MOD;
            m_wrap  = (prev == MOD - 1) ? 1 : 0;
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        #1;
        check_outputs("powerup");

        // Load / hold
        step(0, 1, 0, 16'd0, "load0");
        step(0, 0, 0, 16'd0, "hold0");
        check_eq("hold0_abs", {16'h0, out}, 32'd0);

        // Increment, with a stray value on in that must be ignored
        step(0, 0, 1, 16'd0, "inc1");
        check_eq("inc1_abs", {16'h0, out}, 32'd1);
        step(0, 0, 1, 16'd0, "inc2");
        step(0, 0, 1, 16'h8285, "inc_ignore_in");
        check_eq("inc3_abs", {16'h0, out}, 32'd3);

        // Load beats inc, then count from -32123
        step(0, 1, 1, 16'h8285, "load_over_inc");
        check_eq("neg_load_abs", {16'h0, out}, 32'h8285);
        step(0, 0, 1, 16'h0, "neg_inc1");
        step(0, 0, 1, 16'h0, "neg_inc2");
        step(0, 0, 1, 16'h0, "neg_inc3");
        check_eq("neg_inc3_abs", {16'h0, out}, 32'h8288);

        // Reset priority
        step(0, 1, 0, 16'd12345, "load12345");
        step(1, 1, 1, 16'd12345, "reset_over_all");
        check_eq("reset_abs", {16'h0, out}, 32'd0);
        step(0, 1, 1, 16'd12345, "reload12345");
        step(1, 0, 1, 16'd12345, "reset_over_inc");

        // Wrap at all-ones, then a hold clears the flag
        step(0, 1, 0, 16'hFFFF, "load_ffff");
        step(0, 0, 1, 16'h0, "wrap_inc");
        check_eq("wrap_abs", {16'h0, out}, 32'd0);
        step(0, 0, 0, 16'h0, "wrap_hold");
        // A load of zero is not a wrap
        step(0, 1, 0, 16'h0, "load_zero_nowrap");

        // Reset pulsed entirely between edges has no effect
        step(0, 1, 0, 16'd777, "load777");
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_outputs("midcycle_reset_out");
        step(0, 0, 0, 16'd0, "after_pulse_hold");
        check_eq("after_pulse_abs", {16'h0, out}, 32'd777);
        step(1, 0, 0, 16'd22222, "reset_held");

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            int unsigned rr;
            logic [W-1:0] d;
            rr = $urandom_range(0, 99);
            d  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
            step(rr < 4, $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 65, d, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
